// File: rtl/seg_display_pkg.sv
// seg_display_pkg: shared types, segment codes and helpers for the seven-segment display controller
package seg_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONVERT,
        ST_WRITE
    } state_t;

    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } src_t;

    typedef struct packed {
        logic [3:0] hun;
        logic [3:0] ten;
        logic [3:0] one;
    } bcd3_t;

    localparam int NUM_SCAN = 8;
    localparam logic [3:0] BLANK = 4'hF;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low {dp,g,f,e,d,c,b,a}; any non-decimal nibble (including BLANK) turns the digit off.
    function automatic logic [7:0] seg_encode(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

    // Double-dabble correction applied to each BCD nibble before a shift.
    function automatic logic [3:0] dabble(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

endpackage

// File: rtl/seg_display_ctrl_if.sv
// seg_display_ctrl_if: valid/ready request bundle for the two display requesters plus converter busy
interface seg_display_ctrl_if;
    logic       a_valid;
    logic [7:0] a_value;
    logic       a_ready;
    logic       b_valid;
    logic [7:0] b_value;
    logic       b_ready;
    logic       busy;

    modport master (
        output a_valid, a_value, b_valid, b_value,
        input  a_ready, b_ready, busy
    );

    modport slave (
        input  a_valid, a_value, b_valid, b_value,
        output a_ready, b_ready, busy
    );
endinterface

// File: rtl/bcd_seq_conv.sv
// bcd_seq_conv: 8-cycle sequential double-dabble binary-to-BCD converter for 8-bit values
module bcd_seq_conv
    import seg_display_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] value,
    output logic       done,
    output logic [3:0] hundreds,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    logic [19:0] sr_q, sr_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        run_q, run_d;
    logic [11:0] adj;

    // done marks the cycle whose closing edge performs the 8th shift; digits are final from the next cycle
    assign done     = run_q && (cnt_q == 4'd7);
    assign hundreds = sr_q[19:16];
    assign tens     = sr_q[15:12];
    assign ones     = sr_q[11:8];

    // Load on start, otherwise correct-then-shift while running, MSB of the binary part entering the ones nibble
    always_comb begin
        adj   = {dabble(sr_q[19:16]), dabble(sr_q[15:12]), dabble(sr_q[11:8])};
        sr_d  = sr_q;
        cnt_d = cnt_q;
        run_d = run_q;
        if (start) begin
            sr_d  = {12'd0, value};
            cnt_d = 4'd0;
            run_d = 1'b1;
        end else if (run_q) begin
            sr_d  = {adj[10:0], sr_q[7:0], 1'b0};
            cnt_d = cnt_q + 4'd1;
            run_d = (cnt_q != 4'd7);
        end
    end

    // Converter state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q  <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

endmodule

// File: rtl/seg_display_ctrl.sv
// seg_display_ctrl: round-robin BCD conversion scheduler and 8-digit multiplexed seven-segment scanner
module seg_display_ctrl
    import seg_display_pkg::*;
#(
    parameter int CLK_DIV       = 36864,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    seg_display_ctrl_if.slave     bus,
    output logic [NUM_SCAN-1:0]   anode,
    output logic [7:0]            cathode
);

    localparam int PW = $clog2(CLK_DIV);
    localparam int IW = $clog2(NUM_SCAN);

    state_t            state_q, state_d;
    src_t              src_q, src_d, last_q, last_d;
    bcd3_t             buf_a_q, buf_a_d, buf_b_q, buf_b_d;
    logic [PW-1:0]     psc_q, psc_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              upd_q, upd_d;
    logic [NUM_SCAN-1:0] anode_q, anode_d;
    logic [7:0]        cath_q, cath_d;
    logic              grant_a, grant_b, accept, conv_done, wrap;
    logic [3:0]        hun, ten, one, digit;
    bcd3_t             cur;

    // When both request, the source that was not served last wins
    assign grant_a     = bus.a_valid && (!bus.b_valid || last_q == SRC_B);
    assign grant_b     = bus.b_valid && !grant_a;
    assign bus.a_ready = (state_q == ST_IDLE) && grant_a && !reset;
    assign bus.b_ready = (state_q == ST_IDLE) && grant_b && !reset;
    assign bus.busy    = (state_q != ST_IDLE);
    assign accept      = bus.a_ready || bus.b_ready;
    assign anode       = anode_q;
    assign cathode     = cath_q;

    bcd_seq_conv u_conv (
        .clk      (clk),
        .reset    (reset),
        .start    (accept),
        .value    (bus.a_ready ? bus.a_value : bus.b_value),
        .done     (conv_done),
        .hundreds (hun),
        .tens     (ten),
        .ones     (one)
    );

    // Scheduler: accept in IDLE, wait for the converter, then commit all three digits in one edge
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        last_d  = last_q;
        buf_a_d = buf_a_q;
        buf_b_d = buf_b_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_CONVERT;
                    src_d   = bus.a_ready ? SRC_A : SRC_B;
                end
            end
            ST_CONVERT: state_d = conv_done ? ST_WRITE : ST_CONVERT;
            ST_WRITE: begin
                buf_a_d = (src_q == SRC_A) ? '{hun: hun, ten: ten, one: one} : buf_a_q;
                buf_b_d = (src_q == SRC_B) ? '{hun: hun, ten: ten, one: one} : buf_b_q;
                last_d  = src_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Scheduler registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            src_q   <= SRC_A;
            last_q  <= SRC_B;
            buf_a_q <= '0;
            buf_b_q <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            last_q  <= last_d;
            buf_a_q <= buf_a_d;
            buf_b_q <= buf_b_d;
        end
    end

    // Scan: prescaler advances the digit index; outputs latch once per slot so a buffer write never tears a digit
    always_comb begin
        wrap    = (psc_q == PW'(CLK_DIV - 1));
        psc_d   = wrap ? '0 : psc_q + 1'b1;
        idx_d   = wrap ? idx_q + 1'b1 : idx_q;
        upd_d   = wrap;
        cur     = idx_q[IW-1] ? buf_b_q : buf_a_q;
        digit   = (idx_q[1:0] == 2'd0) ? cur.one :
                  (idx_q[1:0] == 2'd1) ? ((BLANK_LEADING && cur.hun == 4'd0 && cur.ten == 4'd0) ? BLANK : cur.ten) :
                  (idx_q[1:0] == 2'd2) ? ((BLANK_LEADING && cur.hun == 4'd0) ? BLANK : cur.hun) :
                  BLANK;
        anode_d = upd_q ? ~(NUM_SCAN'(1) << idx_q) : anode_q;
        cath_d  = upd_q ? seg_encode(digit) : cath_q;
    end

    // Scan registers; upd resets high so the first edge after release loads slot 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            psc_q   <= '0;
            idx_q   <= '0;
            upd_q   <= 1'b1;
            anode_q <= '1;
            cath_q  <= SEG_BLANK;
        end else begin
            psc_q   <= psc_d;
            idx_q   <= idx_d;
            upd_q   <= upd_d;
            anode_q <= anode_d;
            cath_q  <= cath_d;
        end
    end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// tb_seg_display_ctrl: model-checked directed bench for seg_display_ctrl with and without leading-zero blanking
module tb_seg_display_ctrl;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] anode1, cathode1, anode0, cathode0;
    int         checks = 0;
    int         errors = 0;

    seg_display_ctrl_if bus1 ();
    seg_display_ctrl_if bus0 ();

    assign bus0.a_valid = bus1.a_valid;
    assign bus0.a_value = bus1.a_value;
    assign bus0.b_valid = bus1.b_valid;
    assign bus0.b_value = bus1.b_value;

    always #5 clk = ~clk;

    seg_display_ctrl #(.CLK_DIV(DIV), .BLANK_LEADING(1'b1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1.slave), .anode(anode1), .cathode(cathode1)
    );
    seg_display_ctrl #(.CLK_DIV(DIV), .BLANK_LEADING(1'b0)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0.slave), .anode(anode0), .cathode(cathode0)
    );

    logic [7:0] seg_tab  [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    logic [7:0] scan_seq [9]  = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F, 8'hFE};
    logic [7:0] cath_bl1 [9]  = '{8'hC0, 8'hFF, 8'hFF, 8'hFF, 8'hC0, 8'hFF, 8'hFF, 8'hFF, 8'hC0};
    logic [7:0] cath_bl0 [9]  = '{8'hC0, 8'hC0, 8'hC0, 8'hFF, 8'hC0, 8'hC0, 8'hC0, 8'hFF, 8'hC0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Segment pattern for digit position pos (0 ones, 1 tens, 2 hundreds, 3 spare) of decimal value v
    function automatic logic [7:0] exp_seg(input int v, input int pos, input bit bl);
        if (pos == 3) return 8'hFF;
        if (bl && pos == 2 && v < 100) return 8'hFF;
        if (bl && pos == 1 && v < 10) return 8'hFF;
        return seg_tab[(pos == 0) ? v % 10 : (pos == 1) ? (v / 10) % 10 : v / 100];
    endfunction

    // Model: a request occupies the converter for 9 cycles and its value shows up in that source's buffer at the end
    int         m_left, m_edges, m_buf_a, m_buf_b, m_pend_val;
    bit         m_last_b, m_pend_b;
    logic [7:0] m_cath1, m_cath0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_left     <= 0;
            m_edges    <= 0;
            m_buf_a    <= 0;
            m_buf_b    <= 0;
            m_pend_val <= 0;
            m_pend_b   <= 1'b0;
            m_last_b   <= 1'b1;
            m_cath1    <= 8'hFF;
            m_cath0    <= 8'hFF;
        end else begin
            m_edges <= m_edges + 1;
            if (m_edges % DIV == 0) begin
                m_cath1 <= exp_seg(((m_edges / DIV) % 8 < 4) ? m_buf_a : m_buf_b, (m_edges / DIV) % 4, 1'b1);
                m_cath0 <= exp_seg(((m_edges / DIV) % 8 < 4) ? m_buf_a : m_buf_b, (m_edges / DIV) % 4, 1'b0);
            end
            if (m_left == 0) begin
                if (bus1.a_valid && (!bus1.b_valid || m_last_b)) begin
                    m_left <= 9; m_pend_b <= 1'b0; m_pend_val <= int'(bus1.a_value);
                end else if (bus1.b_valid) begin
                    m_left <= 9; m_pend_b <= 1'b1; m_pend_val <= int'(bus1.b_value);
                end
            end else begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    if (m_pend_b) m_buf_b <= m_pend_val;
                    else m_buf_a <= m_pend_val;
                    m_last_b <= m_pend_b;
                end
            end
        end
    end

    // Every-cycle comparison of both DUTs against the model
    always @(negedge clk) begin
        logic       ea, eb;
        logic [7:0] ean;
        ea  = !reset && m_left == 0 && bus1.a_valid && (!bus1.b_valid || m_last_b);
        eb  = !reset && m_left == 0 && bus1.b_valid && !(bus1.a_valid && (!bus1.b_valid || m_last_b));
        ean = (m_edges == 0) ? 8'hFF : ~(8'd1 << (((m_edges - 1) / DIV) % 8));
        chk("m_anode1", anode1, ean);
        chk("m_anode0", anode0, ean);
        chk("m_cathode1", cathode1, m_cath1);
        chk("m_cathode0", cathode0, m_cath0);
        chk("m_busy", bus1.busy, m_left > 0);
        chk("m_a_ready", bus1.a_ready, ea);
        chk("m_b_ready", bus1.b_ready, eb);
        chk("m_busy0", bus0.busy, m_left > 0);
        chk("m_a_ready0", bus0.a_ready, ea);
        chk("m_b_ready0", bus0.b_ready, eb);
    end

    task automatic wait_ready(input bit which_b, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = which_b ? bus1.b_ready : bus1.a_ready;
        end
    endtask

    // Wait for the scan to enter slot an, then check both DUTs' cathodes there
    task automatic show(input logic [7:0] an, input logic [7:0] c1, input logic [7:0] c0);
        bit         hit;
        logic [7:0] prev;
        hit  = 1'b0;
        prev = anode1;
        for (int i = 0; i < 80 && !hit; i++) begin
            @(negedge clk);
            hit  = (anode1 == an) && (prev != an);
            prev = anode1;
        end
        chk($sformatf("slot_%h_found", an), hit, 1);
        chk($sformatf("slot_%h_cath_bl1", an), cathode1, c1);
        chk($sformatf("slot_%h_cath_bl0", an), cathode0, c0);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        bit ok;
        int busy_n, rdy_n;
        bus1.a_valid = 1'b0; bus1.a_value = 8'd0;
        bus1.b_valid = 1'b0; bus1.b_value = 8'd0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_anode", anode1, 8'hFF);
        chk("rst_cathode", cathode1, 8'hFF);
        chk("rst_busy", bus1.busy, 0);
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 9 * DIV; i++) begin
            @(negedge clk);
            chk("scan_anode", anode1, scan_seq[i / DIV]);
            chk("scan_cath_bl1", cathode1, cath_bl1[i / DIV]);
            chk("scan_cath_bl0", cathode0, cath_bl0[i / DIV]);
        end

        @(posedge clk); #1 bus1.a_value = 8'd255; bus1.a_valid = 1'b1;
        wait_ready(1'b0, ok);
        chk("a255_ready_seen", ok, 1);
        rdy_n  = 1;
        busy_n = 0;
        @(posedge clk); #1 bus1.a_valid = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            busy_n += bus1.busy;
            rdy_n  += bus1.a_ready;
        end
        chk("a255_busy_len", busy_n, 9);
        chk("a255_ready_len", rdy_n, 1);
        show(8'hFE, 8'h92, 8'h92);
        show(8'hFD, 8'h92, 8'h92);
        show(8'hFB, 8'hA4, 8'hA4);

        pulse_reset();
        @(posedge clk); #1
        bus1.a_value = 8'd7;   bus1.a_valid = 1'b1;
        bus1.b_value = 8'd100; bus1.b_valid = 1'b1;
        wait_ready(1'b0, ok);
        chk("ab_a_first", ok, 1);
        chk("ab_b_held", bus1.b_ready, 0);
        @(posedge clk); #1 bus1.a_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk("ab_b_wait", bus1.b_ready, 0);
        end
        @(negedge clk);
        chk("ab_b_granted", bus1.b_ready, 1);
        @(posedge clk); #1 bus1.b_valid = 1'b0;
        repeat (12) @(posedge clk);
        show(8'hFE, 8'hF8, 8'hF8);
        show(8'hFD, 8'hFF, 8'hC0);
        show(8'hFB, 8'hFF, 8'hC0);
        show(8'hEF, 8'hC0, 8'hC0);
        show(8'hDF, 8'hC0, 8'hC0);
        show(8'hBF, 8'hF9, 8'hF9);

        @(posedge clk); #1 bus1.a_value = 8'd5; bus1.a_valid = 1'b1;
        wait_ready(1'b0, ok);
        chk("a5_ready_seen", ok, 1);
        @(posedge clk); #1 bus1.a_valid = 1'b0;
        repeat (12) @(posedge clk);
        show(8'hFE, 8'h92, 8'h92);
        show(8'hFD, 8'hFF, 8'hC0);
        show(8'hFB, 8'hFF, 8'hC0);
        show(8'hF7, 8'hFF, 8'hFF);
        show(8'h7F, 8'hFF, 8'hFF);

        @(posedge clk); #1 bus1.a_value = 8'd200; bus1.a_valid = 1'b1;
        wait_ready(1'b0, ok);
        chk("a200_ready_seen", ok, 1);
        @(posedge clk);
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_anode", anode1, 8'hFF);
        chk("mid_rst_cathode", cathode1, 8'hFF);
        chk("mid_rst_busy", bus1.busy, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid_rst_a_ready", bus1.a_ready, 0);
        end
        @(posedge clk); #1 bus1.a_valid = 1'b0;
        @(posedge clk); #1 reset = 1'b0;
        show(8'hFE, 8'hC0, 8'hC0);
        show(8'hFD, 8'hFF, 8'hC0);
        show(8'hFB, 8'hFF, 8'hC0);
        show(8'hEF, 8'hC0, 8'hC0);
        show(8'hBF, 8'hFF, 8'hC0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_display_ctrl.md
Name: seg_display_ctrl

Overview:
Scheduler and scan controller for the 8-digit multiplexed seven-segment display. Two requesters (A: hit counter, B: secondary score/timer) share one sequential binary-to-BCD converter through a round-robin valid/ready arbiter. Results are stored in per-source digit buffers. A prescaled scan counter drives the active-low anodes and cathodes, with leading-zero blanking.

Parameters:
CLK_DIV, 36864, clk cycles per digit slot (scan prescaler terminal count + 1); must be >= 2
BLANK_LEADING, 1, 1 = blank leading zeros in hundreds/tens; 0 = always show all three digits

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
a_valid  in  1  requester A has a value to display
a_value  in  8  requester A unsigned binary value (0..255)
a_ready  out  1  A value accepted on this edge when a_valid && a_ready
b_valid  in  1  requester B has a value to display
b_value  in  8  requester B unsigned binary value
b_ready  out  1  B accept strobe, same rules as a_ready
busy  out  1  converter occupied (CONVERT or WRITE)
anode  out  8  digit enables, active low, one-hot zero
cathode  out  8  segments {dp,g,f,e,d,c,b,a}, active low

Behaviour:
- Reset (async, immediate): anode=8'hFF, cathode=8'hFF, busy=0, a_ready=b_ready=0, both buffers = {0,0,0}, last_grant=B, prescaler=0, scan index=0, FSM=IDLE.
- FSM states: IDLE, CONVERT, WRITE.
- IDLE: if exactly one valid, grant it. If both valid, grant the source != last_grant.
  - Ready is combinational: x_ready = (state==IDLE) && grant_x. At most one ready is high per cycle.
  - On that edge, capture the value and source, then go to CONVERT.
- CONVERT: 8 cycles of double-dabble, MSB first. Each cycle: add 3 to any BCD nibble >= 5, then shift left one bit, shifting in the next value bit. The 4-bit iteration counter ends after the 8th shift, then go to WRITE.
- WRITE: one cycle. Store {hundreds,tens,ones} into the granted source's buffer, set last_grant = source, return to IDLE.
- Latency: accept edge T; buffer updated at edge T+9. The next accept is possible at edge T+10.
- busy is high during CONVERT and WRITE. Requests arriving while busy wait, with the requester holding value and valid. A valid dropped before accept is ignored.
- Scan timing:
  - prescaler counts 0..CLK_DIV-1. On wrap, the 3-bit index increments 7->0.
  - anode and cathode are registered and update the edge after the index changes.
  - After reset release, the first edge loads index 0.
- Digit map:
  - index0 = A ones, 1 = A tens, 2 = A hundreds, 3 = blank.
  - index4 = B ones, 5 = B tens, 6 = B hundreds, 7 = blank.
  - anode[index]=0, all other anode bits = 1.
- Segment codes: 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8 8:80 9:90 blank:FF. dp is always 1.
- Blanking (BLANK_LEADING=1):
  - hundreds is blank if 0.
  - tens is blank if hundreds==0 and tens==0.
  - ones is always shown.
- Buffer updates take effect at the next scan of that digit. No tearing: all three digits are written in one edge.
- Reset mid-conversion: the conversion is abandoned, buffers clear to 0, and no ready is issued until IDLE after release.

Decomposition:
- Package seg_display_pkg holds:
  - FSM state enum
  - BLANK nibble code 4'hF
  - segment constants SEG_0..SEG_9 and SEG_BLANK
  - NUM_SCAN=8
  - source IDs SRC_A/SRC_B
- Sub-module bcd_seq_conv: start/value in; done/hundreds/tens/ones out; 8-cycle double-dabble with its own counter. It is reused by the FSM and is verifiable stand-alone.

Test Plan:
- Reset: during reset, anode=FF and cathode=FF. After release (CLK_DIV=4), the index0 slot shows anode=FE, cathode=C0. The index1 and index2 slots show cathode=FF.
- A sends 255 from IDLE: a_ready high for exactly 1 cycle, busy high for 9 cycles, buffer A={2,5,5}. Scan shows FE->92, FD->92, FB->A4.
- A and B valid in the same cycle after reset, A=7, B=100:
  - A is granted first (last_grant=B) and b_ready stays 0 for 10 cycles. B is granted at T+10.
  - Display FE->F8, FD->FF, FB->FF, EF->C0, DF->C0, BF->F9.
- BLANK_LEADING=0 with A=5: FE->92, FD->C0, FB->C0. Slots 3 and 7 are always FF.
- Reset asserted on the 4th CONVERT cycle after A=200: anode and cathode go FF asynchronously, buffer A reads 0 after release, a_ready stays 0 while reset is held.
- Scan wrap with CLK_DIV=4: anode sequence FE,FD,FB,F7,EF,DF,BF,7F,FE, each held exactly 4 cycles.
